ifetch_pq: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue and a valid/grant instruction-memory handshake. It issues sequential fetches ahead of decode and buffers up to DEPTH instructions. It supports decode stall and flush, and redirects on taken branches/jumps from Execute, discarding stale in-flight data. It sits between the PC/imem and the decode stage, and drives the IF/ID outputs directly.

---
 rtl/ifetch_pq.sv | 120 ++++++++++++
 tb/tb_ifetch_pq.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_pq.sv
// Instruction fetch stage: single-outstanding valid/grant imem port feeding a
// DEPTH-entry prefetch queue, which in turn feeds the IF/ID registers.
module ifetch_pq #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t          q [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pcf, req_pc;
  logic            outstanding, discard;

  logic            grant, resp, push, pop;
  logic [CW:0]     occ;
  entry_t          head_e;
  logic            unused_tgt_lsb;

  assign unused_tgt_lsb = ^PCTargetE[1:0];
  assign imem_addr      = pcf;

  // Request/queue control; the outstanding word always has a queue slot reserved.
  always_comb begin
    occ      = {1'b0, count} + (CW+1)'(outstanding);
    imem_req = reset & (~outstanding | imem_rvalid) & (occ < (CW+1)'(DEPTH)) & ~PCSrcE;
    grant    = imem_req & imem_gnt;
    resp     = imem_rvalid & outstanding;
    push     = resp & ~discard & ~PCSrcE;
    pop      = ~FlushD & ~StallD & (count != '0);
    head_e   = q[head];
  end

  // Fetch pointer, outstanding/discard tracking and queue pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcf         <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      if (PCSrcE)     pcf <= {PCTargetE[XLEN-1:2], 2'b00};
      else if (grant) pcf <= pcf + XLEN'(4);

      if (grant) req_pc <= pcf;

      if (grant)     outstanding <= 1'b1;
      else if (resp) outstanding <= 1'b0;

      // A request still in flight across a redirect returns stale data.
      if (PCSrcE)    discard <= outstanding & ~imem_rvalid;
      else if (resp) discard <= 1'b0;

      if (PCSrcE) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  // Queue storage needs no reset; count qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) q[tail] <= '{pc: req_pc, instr: imem_rdata};
  end

  // IF/ID registers: flush beats stall beats pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ValidD   <= 1'b0;
      InstrD   <= '0;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (FlushD) begin
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (count != '0) begin
        ValidD   <= 1'b1;
        InstrD   <= head_e.instr;
        PCD      <= head_e.pc;
        PCPlus4D <= head_e.pc + XLEN'(4);
      end else begin
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_pq.sv
// Bench for ifetch_pq: randomized imem responder plus a program-order model of
// the fetch address stream and the decoded PC/instruction stream.
module tb_ifetch_pq;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] KEY      = 32'h5A5A_5A5A;

  logic        clk, reset, PCSrcE, StallD, FlushD;
  logic        imem_req, imem_gnt, imem_rvalid, ValidD;
  logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;

  ifetch_pq #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallD(StallD), .FlushD(FlushD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_presented = 0;

  // responder knobs and state
  int          gnt_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;
  bit          hold_resp = 1'b0;
  bit          force_now = 1'b0;
  bit          resp_pend = 1'b0;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = '0;

  // program-order model: next address to fetch, next PC to present
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] exp_pc = RESET_PC;

  logic        cap_reset = 1'b0, cap_flush = 1'b0, cap_stall = 1'b0;
  logic        cap_pcsrc = 1'b0, cap_req = 1'b0, cap_gnt = 1'b0;
  logic [31:0] cap_addr = '0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_instr = '0, prev_pc = '0, prev_pc4 = '0;

  // Environment: responder drives at negedge+2, outputs checked at +3, edge sampled at +4.
  initial begin : env
    logic [31:0] e4;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      imem_rvalid = 1'b0;
      if (resp_pend && (force_now || (!hold_resp && resp_cnt == 0))) begin
        imem_rvalid = 1'b1;
        imem_rdata  = resp_addr ^ KEY;
        resp_pend   = 1'b0;
      end else if (resp_pend && !hold_resp) begin
        resp_cnt--;
      end
      imem_gnt = (int'($urandom_range(99, 0)) < gnt_pct);
      #1;
      if (reset && cap_reset) begin
        if (cap_flush) begin
          n_checks++;
          if (ValidD !== 1'b0) begin
            n_fail++; $display("FAIL flush_bubble: ValidD=%b required 0", ValidD);
          end
        end else if (cap_stall) begin
          n_checks++;
          if ({ValidD, InstrD, PCD, PCPlus4D} !== {prev_valid, prev_instr, prev_pc, prev_pc4}) begin
            n_fail++;
            $display("FAIL stall_hold: got v=%b i=%h pc=%h pc4=%h required v=%b i=%h pc=%h pc4=%h",
                     ValidD, InstrD, PCD, PCPlus4D, prev_valid, prev_instr, prev_pc, prev_pc4);
          end
        end else if (ValidD === 1'b1) begin
          e4 = exp_pc + 32'd4;
          n_checks++;
          if (PCD !== exp_pc || PCPlus4D !== e4 || InstrD !== (exp_pc ^ KEY)) begin
            n_fail++;
            $display("FAIL stream: got pc=%h pc4=%h instr=%h required pc=%h pc4=%h instr=%h",
                     PCD, PCPlus4D, InstrD, exp_pc, e4, exp_pc ^ KEY);
          end
          exp_pc = e4;
          n_presented++;
        end
        if (cap_req && !cap_gnt && !cap_pcsrc && !PCSrcE) begin
          n_checks++;
          if (imem_req !== 1'b1 || imem_addr !== cap_addr) begin
            n_fail++;
            $display("FAIL req_hold: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, cap_addr);
          end
        end
        if (PCSrcE) begin
          n_checks++;
          if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL req_in_redirect: imem_req=%b required 0", imem_req);
          end
        end
      end
      prev_valid = ValidD; prev_instr = InstrD; prev_pc = PCD; prev_pc4 = PCPlus4D;
      #1;
      cap_reset = reset; cap_flush = FlushD; cap_stall = StallD; cap_pcsrc = PCSrcE;
      cap_req = imem_req; cap_gnt = imem_gnt; cap_addr = imem_addr;
      if (reset && imem_req && imem_gnt) begin
        n_checks++;
        if (imem_addr !== exp_fetch || resp_pend) begin
          n_fail++;
          $display("FAIL fetch_order: addr=%h unanswered=%0b required addr=%h unanswered=0",
                   imem_addr, resp_pend, exp_fetch);
        end
        exp_fetch = exp_fetch + 32'd4;
        resp_pend = 1'b1;
        resp_addr = imem_addr;
        resp_cnt  = int'($urandom_range(lat_max, lat_min));
      end
      if (!reset) begin
        exp_fetch = RESET_PC; exp_pc = RESET_PC;
      end else if (PCSrcE) begin
        exp_fetch = {PCTargetE[31:2], 2'b00}; exp_pc = exp_fetch;
      end
    end
  end

  task automatic wait_first_valid(input string name, input logic [31:0] want_pc);
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #3;
      if (ValidD === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || PCD !== want_pc) begin
      n_fail++;
      $display("FAIL %s: found=%0b PCD=%h required found=1 PCD=%h", name, found, PCD, want_pc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0; FlushD = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL reset_req: req=%b addr=%h required req=0 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    n_checks++;
    if ({ValidD, InstrD, PCD, PCPlus4D} !== '0) begin
      n_fail++; $display("FAIL reset_ifid: v=%b i=%h pc=%h pc4=%h required all 0", ValidD, InstrD, PCD, PCPlus4D);
    end
    @(negedge clk); #1;
    reset = 1'b1;
    #2;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL first_req: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #3;
      n_checks++;
      if (ValidD !== (k == 3)) begin
        n_fail++; $display("FAIL first_valid_cycle%0d: ValidD=%b required %0b", k, ValidD, (k == 3));
      end
    end
    n_checks++;
    if (PCD !== RESET_PC || PCPlus4D !== RESET_PC + 32'd4) begin
      n_fail++; $display("FAIL first_pc: PCD=%h PCPlus4D=%h required %h %h", PCD, PCPlus4D, RESET_PC, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #3;
      n_checks++;
      if (ValidD !== 1'b1) begin
        n_fail++; $display("FAIL throughput: cycle %0d ValidD=%b required 1", k, ValidD);
      end
    end
  endtask

  task automatic test_stall_full();
    @(negedge clk); #1;
    StallD = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    n_checks++;
    if (imem_req !== 1'b0 || (exp_fetch - exp_pc) !== 32'(DEPTH * 4)) begin
      n_fail++;
      $display("FAIL stall_full: req=%b words_ahead=%0d required req=0 words_ahead=%0d",
               imem_req, (exp_fetch - exp_pc) / 4, DEPTH);
    end
    @(negedge clk); #1;
    StallD = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_wait_states();
    logic [31:0] a0;
    bit bubble = 1'b0;
    @(negedge clk); #1;
    gnt_pct = 0;
    #2;
    a0 = imem_addr;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #3; end
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== a0) begin
        n_fail++; $display("FAIL wait_hold: cycle %0d req=%b addr=%h required req=1 addr=%h", k, imem_req, imem_addr, a0);
      end
      if (ValidD === 1'b0) bubble = 1'b1;
    end
    n_checks++;
    if (!bubble) begin
      n_fail++; $display("FAIL wait_bubble: saw_bubble=0 required 1");
    end
    @(negedge clk); #1;
    gnt_pct = 100;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_redirect_inflight();
    bit found = 1'b0;
    @(negedge clk); #1;
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (resp_pend && resp_cnt == 3) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL inflight_setup: grant seen=0 required 1");
    end
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h0000_0203;
    @(negedge clk); #1;
    PCSrcE = 1'b0; FlushD = 1'b0;
    lat_min = 0; lat_max = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      #2;
      if (imem_req && imem_gnt) found = 1'b1;
    end
    n_checks++;
    if (!found || imem_addr !== 32'h0000_0200) begin
      n_fail++; $display("FAIL inflight_addr: granted=%0b addr=%h required 1 00000200", found, imem_addr);
    end
    wait_first_valid("inflight_first_pc", 32'h0000_0200);
  endtask

  task automatic test_redirect_rvalid();
    bit found = 1'b0;
    logic [31:0] tgt;
    @(negedge clk); #1;
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (resp_pend && resp_cnt == 0 && !hold_resp) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL coincide_setup: response due=0 required 1");
    end
    tgt = 32'h0000_0400 + 32'($urandom_range(255, 0));
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = tgt;
    @(negedge clk); #1;
    PCSrcE = 1'b0; FlushD = 1'b0;
    lat_min = 0; lat_max = 0;
    #2;
    n_checks++;
    if (ValidD !== 1'b0) begin
      n_fail++; $display("FAIL coincide_flush: ValidD=%b required 0", ValidD);
    end
    @(negedge clk); #3;
    n_checks++;
    if (ValidD !== 1'b0) begin
      n_fail++; $display("FAIL coincide_queue_empty: ValidD=%b required 0", ValidD);
    end
    wait_first_valid("coincide_first_pc", {tgt[31:2], 2'b00});
  endtask

  task automatic test_wrap();
    bit found = 1'b0;
    @(negedge clk); #1;
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'hFFFF_FFF8;
    @(negedge clk); #1;
    PCSrcE = 1'b0; FlushD = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #3;
      if (ValidD === 1'b1 && PCD === 32'hFFFF_FFFC) found = 1'b1;
    end
    n_checks++;
    if (!found || PCPlus4D !== 32'h0) begin
      n_fail++; $display("FAIL wrap_pc4: found=%0b PCPlus4D=%h required 1 00000000", found, PCPlus4D);
    end
    @(negedge clk); #3;
    n_checks++;
    if (ValidD !== 1'b1 || PCD !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next: ValidD=%b PCD=%h required 1 00000000", ValidD, PCD);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    @(negedge clk); #1;
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (resp_pend && resp_cnt == 4) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL midreset_setup: grant seen=0 required 1");
    end
    hold_resp = 1'b1; gnt_pct = 0; reset = 1'b0;
    repeat (2) begin
      @(negedge clk); #3;
      n_checks++;
      if (imem_req !== 1'b0 || imem_addr !== RESET_PC || ValidD !== 1'b0 || PCD !== '0) begin
        n_fail++;
        $display("FAIL midreset_state: req=%b addr=%h v=%b pc=%h required 0 %h 0 0", imem_req, imem_addr, ValidD, PCD, RESET_PC);
      end
    end
    @(negedge clk); #1;
    reset = 1'b1; force_now = 1'b1;
    #2;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL midreset_restart: req=%b addr=%h required 1 %h", imem_req, imem_addr, RESET_PC);
    end
    @(negedge clk); #1;
    force_now = 1'b0; hold_resp = 1'b0; gnt_pct = 100; lat_min = 0; lat_max = 0;
    wait_first_valid("midreset_first_pc", RESET_PC);
    n_checks++;
    if (InstrD !== (RESET_PC ^ KEY)) begin
      n_fail++; $display("FAIL midreset_instr: InstrD=%h required %h", InstrD, RESET_PC ^ KEY);
    end
  endtask

  task automatic test_random();
    int p0 = n_presented;
    int r;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); #1;
      if (c % 50 == 0) begin
        gnt_pct = int'($urandom_range(100, 40));
        lat_min = 0;
        lat_max = int'($urandom_range(3, 0));
      end
      StallD = ($urandom_range(99, 0) < 20);
      r = int'($urandom_range(99, 0));
      if (r < 3) begin
        PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = $urandom();
      end else begin
        PCSrcE = 1'b0; FlushD = (r < 10);
      end
    end
    @(negedge clk); #1;
    StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; gnt_pct = 100; lat_max = 0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_presented - p0 < 50) begin
      n_fail++; $display("FAIL random_progress: presented=%0d required at least 50", n_presented - p0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall_full();
    test_wait_states();
    test_redirect_inflight();
    test_redirect_rvalid();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
